// File: rtl/dff_shift_bank_pkg.sv
// dff_shift_bank_pkg: mode encoding, fill-counter width and word parity helpers for dff_shift_bank
package dff_shift_bank_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;
  localparam int PAR_MAX_W = 1024;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  // zero-extension to PAR_MAX_W leaves the XOR of the word unchanged
  function automatic logic word_parity(input logic [PAR_MAX_W-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one negedge word register with valid flag; carries a parity bit when DFF_SHIFT_BANK_PARITY_EN is defined
module dff_stage
  import dff_shift_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_ld_d,
`ifdef DFF_SHIFT_BANK_PARITY_EN
  input  logic             i_par,
  output logic             o_par,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (ld) begin
      r_q     <= i_ld_d;
      r_valid <= 1'b1;
    end else if (en) begin
      r_q     <= i_d;
      r_valid <= i_valid;
    end
  assign o_q     = r_q;
  assign o_valid = r_valid;
`ifdef DFF_SHIFT_BANK_PARITY_EN
  logic r_par;
  always_ff @(negedge clk or posedge rst)
    if (rst) r_par <= 1'b0;
    else if (clr) r_par <= 1'b0;
    else if (ld) r_par <= word_parity(PAR_MAX_W'(i_ld_d));
    else if (en) r_par <= i_par;
  assign o_par = r_par;
`endif
endmodule

// File: rtl/dff_shift_bank.sv
// dff_shift_bank: WIDTH x DEPTH negedge delay line with valid tracking, parallel load, clear and fill counter
// Optional sticky parity checking is built when DFF_SHIFT_BANK_PARITY_EN is defined.
module dff_shift_bank
  import dff_shift_bank_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       d,
  input  logic                   d_valid,
  input  logic [WIDTH*DEPTH-1:0] load_data,
`ifdef DFF_SHIFT_BANK_PARITY_EN
  input  logic                   inject_err,
  output logic                   parity_err,
`endif
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [WIDTH*DEPTH-1:0] q_all,
  output logic [CNT_W-1:0]       fill_count
);
  mode_e                  w_mode;
  logic                   w_shift;
  logic                   w_load;
  logic                   w_clr;
  logic [WIDTH*DEPTH-1:0] w_all;
  logic [DEPTH-1:0]       w_valid;
  logic [CNT_W-1:0]       r_fill;
  assign w_mode  = mode_e'(mode);
  assign w_shift = w_mode == MODE_SHIFT;
  assign w_load  = w_mode == MODE_LOAD;
  assign w_clr   = w_mode == MODE_CLEAR;
`ifdef DFF_SHIFT_BANK_PARITY_EN
  logic [DEPTH-1:0] w_par;
`endif
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] w_d_in;
    logic             w_v_in;
`ifdef DFF_SHIFT_BANK_PARITY_EN
    logic             w_p_in;
`endif
    if (g == 0) begin : g_head
      assign w_d_in = d;
      assign w_v_in = d_valid;
`ifdef DFF_SHIFT_BANK_PARITY_EN
      assign w_p_in = word_parity(PAR_MAX_W'(d)) ^ inject_err;
`endif
    end else begin : g_body
      assign w_d_in = w_all[(g-1)*WIDTH +: WIDTH];
      assign w_v_in = w_valid[g-1];
`ifdef DFF_SHIFT_BANK_PARITY_EN
      assign w_p_in = w_par[g-1];
`endif
    end
    dff_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (w_shift),
      .ld     (w_load),
      .clr    (w_clr),
      .i_d    (w_d_in),
      .i_valid(w_v_in),
      .i_ld_d (load_data[g*WIDTH +: WIDTH]),
`ifdef DFF_SHIFT_BANK_PARITY_EN
      .i_par  (w_p_in),
      .o_par  (w_par[g]),
`endif
      .o_q    (w_all[g*WIDTH +: WIDTH]),
      .o_valid(w_valid[g])
    );
  end
  // entry and exit on the same shift edge cancel, so the modular sum never leaves 0..DEPTH
  always_ff @(negedge clk or posedge rst)
    if (rst) r_fill <= '0;
    else if (w_clr) r_fill <= '0;
    else if (w_load) r_fill <= CNT_W'(DEPTH);
    else if (w_shift) r_fill <= r_fill + CNT_W'(d_valid) - CNT_W'(w_valid[DEPTH-1]);
`ifdef DFF_SHIFT_BANK_PARITY_EN
  logic r_perr;
  logic w_tail_bad;
  // judge the word about to land in the output stage so the flag rises on that same edge
  assign w_tail_bad = g_stage[DEPTH-1].w_v_in &&
                      (word_parity(PAR_MAX_W'(g_stage[DEPTH-1].w_d_in)) != g_stage[DEPTH-1].w_p_in);
  always_ff @(negedge clk or posedge rst)
    if (rst) r_perr <= 1'b0;
    else if (w_clr) r_perr <= 1'b0;
    else if (w_shift && w_tail_bad) r_perr <= 1'b1;
  assign parity_err = r_perr;
`endif
  assign q          = w_all[(DEPTH-1)*WIDTH +: WIDTH];
  assign q_valid    = w_valid[DEPTH-1];
  assign q_all      = w_all;
  assign fill_count = r_fill;
  a_fill_popcount: assert property (@(posedge clk) disable iff (rst)
    r_fill == CNT_W'($countones(w_valid)));
  a_mode_known: assert property (@(negedge clk) disable iff (rst) !$isunknown(mode));
endmodule

// File: tb/tb_dff_shift_bank.sv
// tb_dff_shift_bank: directed and random checks of dff_shift_bank against an array-based model
module tb_dff_shift_bank;
  import dff_shift_bank_pkg::*;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = cnt_width(D);
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     mode;
  logic [W-1:0]   d;
  logic           d_valid;
  logic [W*D-1:0] load_data;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [W*D-1:0] q_all;
  logic [CW-1:0]  fill_count;
`ifdef DFF_SHIFT_BANK_PARITY_EN
  logic inject_err;
  logic parity_err;
`endif
  logic [W-1:0] md [D];
  logic         mv [D];
  logic         mp [D];
  logic         merr;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dff_shift_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .d         (d),
    .d_valid   (d_valid),
    .load_data (load_data),
`ifdef DFF_SHIFT_BANK_PARITY_EN
    .inject_err(inject_err),
    .parity_err(parity_err),
`endif
    .q         (q),
    .q_valid   (q_valid),
    .q_all     (q_all),
    .fill_count(fill_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      md[i] = '0;
      mv[i] = 1'b0;
      mp[i] = 1'b0;
    end
    merr = 1'b0;
  endtask
  task automatic model_edge(input logic [1:0] m, input logic [W-1:0] dd, input logic dv,
                            input logic [W*D-1:0] ld, input logic inj);
    if (m == 2'b01) begin
      for (int i = D - 1; i > 0; i--) begin
        md[i] = md[i-1];
        mv[i] = mv[i-1];
        mp[i] = mp[i-1];
      end
      md[0] = dd;
      mv[0] = dv;
      mp[0] = (^dd) ^ inj;
      if (mv[D-1] && (mp[D-1] != ^md[D-1])) merr = 1'b1;
    end else if (m == 2'b10) begin
      for (int i = 0; i < D; i++) begin
        md[i] = ld[i*W +: W];
        mv[i] = 1'b1;
        mp[i] = ^ld[i*W +: W];
      end
    end else if (m == 2'b11) model_reset();
  endtask
  task automatic check_state(input string tag);
    logic [W*D-1:0] e_all;
    int             n;
    n = 0;
    for (int i = 0; i < D; i++) begin
      e_all[i*W +: W] = md[i];
      n += int'(mv[i]);
    end
    chk({tag, "_q"}, 64'(q), 64'(md[D-1]));
    chk({tag, "_qv"}, 64'(q_valid), 64'(mv[D-1]));
    chk({tag, "_qall"}, 64'(q_all), 64'(e_all));
    chk({tag, "_fill"}, 64'(fill_count), 64'(n));
`ifdef DFF_SHIFT_BANK_PARITY_EN
    chk({tag, "_perr"}, 64'(parity_err), 64'(merr));
`endif
  endtask
  task automatic step(input logic [1:0] m, input logic [W-1:0] dd, input logic dv,
                      input logic [W*D-1:0] ld, input logic inj, input string tag);
    @(posedge clk);
    mode      = m;
    d         = dd;
    d_valid   = dv;
    load_data = ld;
`ifdef DFF_SHIFT_BANK_PARITY_EN
    inject_err = inj;
`endif
    @(negedge clk);
    model_edge(m, dd, dv, ld, inj);
    #1;
    check_state(tag);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [W*D-1:0] rl;
    int             r;
    mode      = 2'b00;
    d         = '0;
    d_valid   = 1'b0;
    load_data = '0;
`ifdef DFF_SHIFT_BANK_PARITY_EN
    inject_err = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check_state("reset");
    step(2'b01, 8'hA5, 1'b1, '0, 1'b0, "lat0");
    chk("lat0_fill_const", 64'(fill_count), 64'd1);
    for (int i = 1; i < 4; i++) step(2'b01, 8'h00, 1'b0, '0, 1'b0, "lat");
    chk("lat3_q_const", 64'(q), 64'hA5);
    chk("lat3_qv_const", 64'(q_valid), 64'd1);
    step(2'b01, 8'h00, 1'b0, '0, 1'b0, "lat4");
    chk("lat4_fill_const", 64'(fill_count), 64'd0);
    step(2'b10, 8'h00, 1'b0, 32'h44332211, 1'b0, "load");
    chk("load_qall_const", 64'(q_all), 64'h44332211);
    chk("load_fill_const", 64'(fill_count), 64'd4);
    step(2'b01, 8'h55, 1'b1, '0, 1'b0, "load_shift");
    chk("ls_q_const", 64'(q), 64'h33);
    chk("ls_qall_const", 64'(q_all), 64'h33221155);
    chk("ls_fill_const", 64'(fill_count), 64'd4);
    step(2'b11, 8'h00, 1'b0, '0, 1'b0, "clear_full");
    chk("clear_qall_const", 64'(q_all), 64'd0);
    step(2'b01, 8'h11, 1'b1, '0, 1'b0, "bub0");
    step(2'b01, 8'h22, 1'b0, '0, 1'b0, "bub1");
    step(2'b01, 8'h33, 1'b1, '0, 1'b0, "bub2");
    step(2'b00, 8'hFF, 1'b1, '1, 1'b0, "hold0");
    step(2'b00, 8'hFF, 1'b1, '1, 1'b0, "hold1");
    chk("hold_fill_const", 64'(fill_count), 64'd2);
    for (int i = 0; i < 3; i++) step(2'b01, 8'h00, 1'b0, '0, 1'b0, "bub_drain");
    step(2'b10, 8'h00, 1'b0, 32'hDEADBEEF, 1'b0, "pre_rst_load");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    mode = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("clr_rst_rel");
`ifdef DFF_SHIFT_BANK_PARITY_EN
    step(2'b01, 8'h0F, 1'b1, '0, 1'b1, "par0");
    step(2'b01, 8'h01, 1'b1, '0, 1'b0, "par1");
    step(2'b01, 8'h03, 1'b1, '0, 1'b0, "par2");
    chk("par2_perr_const", 64'(parity_err), 64'd0);
    step(2'b01, 8'h07, 1'b1, '0, 1'b0, "par3");
    chk("par3_perr_const", 64'(parity_err), 64'd1);
    step(2'b01, 8'h00, 1'b1, '0, 1'b0, "par4");
    chk("par4_perr_const", 64'(parity_err), 64'd1);
    step(2'b11, 8'h00, 1'b0, '0, 1'b0, "par_clr");
    chk("parclr_perr_const", 64'(parity_err), 64'd0);
`endif
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 9));
      for (int i = 0; i < D; i++) rl[i*W +: W] = W'($urandom);
      step(r < 6 ? 2'b01 : r == 7 ? 2'b10 : r == 8 ? 2'b11 : 2'b00, W'($urandom),
           1'($urandom), rl, $urandom_range(0, 15) == 0, "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
